ctrl_seq_unit: RTL and testbench
================================

Name: ctrl_seq_unit

Overview:
- Parametrised successor to the fixed 16-bit control unit.
- Multi-cycle sequencer and decoder for the MSP430-style core. Sits between the instruction memory port, the register bank and the ALU.
- Adds a ready/valid fetch handshake, real conditional-branch evaluation from status flags, and a sign-extended byte-scaled PC offset.
- Adds no-writeback handling for CMP/BIT, illegal-opcode detection, and generalised widths.

Parameters:
- INSTR_W, 16, instruction width; only 16 is supported, checked by elaboration assertion.
- PC_W, 16, program counter / branch offset width, must be >= 11.
- REG_AW, 4, register-bank address width.
- OP_W, 5, ALU op_code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- instr  in  INSTR_W  instruction word from memory.
- instr_valid  in  1  instr is valid this cycle.
- fetch_req  out  1  controller ready to accept an instruction.
- flags  in  4  status {V,N,Z,C} from the status register.
- pc_inc  out  1  one-cycle pulse: PC += 2.
- branch_en  out  1  one-cycle pulse: PC += pc_offset.
- pc_offset  out  PC_W  signed byte offset.
- src_reg, dst_reg, wr_reg  out  REG_AW  register-bank addresses.
- wr_en  out  1  register write strobe.
- op_code  out  OP_W  ALU operation.
- byte_mode  out  1  .B variant.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- fsm_state  out  6  one-hot {HALT,WB,EXEC,DECODE,FETCH,IDLE}.

Behaviour:
- Reset values:
  - State is IDLE; fsm_state=6'b000001.
  - All other outputs are 0, including op_code, pc_offset and all register addresses.
  - Reset asserted mid-instruction aborts immediately; fetch_req and wr_en drop asynchronously and the partly decoded instruction is discarded.
- IDLE: one cycle, then FETCH.
- FETCH:
  - fetch_req=1.
  - On instr_valid=1: capture IR, pulse pc_inc, go to DECODE.
  - Wait indefinitely otherwise.
  - instr_valid outside FETCH is ignored.
- DECODE: registered outputs update at the end of this cycle.
  - [15:13]=001 is a jump: cond=[12:10], pc_offset = sign_extend([9:0]) << 1, truncated or extended to PC_W.
  - [15:10]=000100 is a single-op; sub-op=[9:7], byte_mode=[6], reg=[3:0]. Encodings:
    - RRC gives 0x10, or 0x11 for .B.
    - SWPB gives 0x12.
    - RRA gives 0x13, or 0x14 for .B.
    - SXT gives 0x15.
    - PUSH gives 0x16, or 0x17 for .B; src_reg=reg, wr_reg=1 (SP).
    - CALL gives 0x18; dst_reg=reg, wr_reg=1.
    - Other single-ops write dst_reg=wr_reg=reg.
    - Sub-op 6 (RETI) and sub-op 7 are illegal.
  - [15:12]=4..F is a double-op: op_code=[15:12]-4 (0x00..0x0B), src_reg=[11:8], dst_reg=wr_reg=[3:0], byte_mode=[6].
  - Anything else (including 000x other than 000100) is illegal: pulse illegal, go to FETCH, no write.
- EXEC:
  - ALU ops: one cycle, then WB. CMP (0x05) and BIT (0x07) go to FETCH instead, with no write.
  - Jumps: evaluate cond; if taken, pulse branch_en. Then go to FETCH; a jump never writes.
  - Cond table:
    - 0 JNE: !Z
    - 1 JEQ: Z
    - 2 JNC: !C
    - 3 JC: C
    - 4 JN: N
    - 5 JGE: N==V
    - 6 JL: N!=V
    - 7 JMP: always
  - Flags are sampled in EXEC, not at fetch.
- WB: wr_en=1 for exactly one cycle, then FETCH.
- Latency with zero-wait fetch (instr_valid already high): ALU op with write = 4 cycles, CMP/BIT/jump = 3, illegal = 2.
- op_code, registers and pc_offset hold their values until the next DECODE.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - On completion of every instruction (after WB, EXEC-jump, no-write EXEC, or illegal DECODE) the FSM enters HALT instead of FETCH.
  - HALT has fetch_req=0 and leaves HALT on the step=1 cycle.
  - A step held high advances one instruction per pass.
  - Reset still goes to IDLE.
- Undefined: no step port; HALT is unreachable and its fsm_state bit stays 0.

Decomposition:
- Package ctrl_seq_pkg holds:
  - state enum and one-hot constants;
  - single-op and double-op op_code constants;
  - cond-code constants;
  - fixed SP index (1).
- Sub-module ctrl_seq_decode: purely combinational IR-to-{class, op_code, regs, offset, byte_mode, illegal} decode. The top keeps the FSM, the handshake and the output registers.

Test Plan:
- ADD R5,R6 (instr=16'h5506), instr_valid tied high → pc_inc in cycle 1; op_code=0x01, src=5, dst=wr=6; wr_en pulse in cycle 4; fetch_req high again in cycle 5.
- CMP R2,R3 (16'h9203) → op_code=0x05, no wr_en pulse, next fetch after 3 cycles.
- JEQ +4 words (16'h2404):
  - flags Z=1 → branch_en pulse with pc_offset=8.
  - flags Z=0 → no branch_en.
  - JMP -1 (16'h3FFF) → pc_offset=16'hFFFE.
- Fetch wait: instr_valid low for 5 cycles → fetch_req stays 1, no pc_inc; accept on the 6th cycle. Also: instr_valid pulsed during EXEC is ignored.
- Illegal 16'h0000 and RETI 16'h1300 → illegal pulse, no wr_en/branch_en, return to FETCH.
- Reset asserted during WB → wr_en drops in the same cycle, fsm_state=000001. With CTRL_SINGLE_STEP_EN: FSM holds in HALT until step=1.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the ctrl_seq_unit sequencer/decoder.
// States are one-hot so the state register doubles as the fsm_state output.
package ctrl_seq_pkg;

    localparam logic [5:0] OhIdle   = 6'b000001;
    localparam logic [5:0] OhFetch  = 6'b000010;
    localparam logic [5:0] OhDecode = 6'b000100;
    localparam logic [5:0] OhExec   = 6'b001000;
    localparam logic [5:0] OhWb     = 6'b010000;
    localparam logic [5:0] OhHalt   = 6'b100000;

    typedef enum logic [5:0] {
        StIdle   = OhIdle,
        StFetch  = OhFetch,
        StDecode = OhDecode,
        StExec   = OhExec,
        StWb     = OhWb,
        StHalt   = OhHalt
    } state_e;

    typedef enum logic [1:0] {
        ClsAlu     = 2'd0,
        ClsJump    = 2'd1,
        ClsIllegal = 2'd2
    } cls_e;

    // Single-op sub-op field [9:7]
    localparam logic [2:0] SubRrc  = 3'd0;
    localparam logic [2:0] SubSwpb = 3'd1;
    localparam logic [2:0] SubRra  = 3'd2;
    localparam logic [2:0] SubSxt  = 3'd3;
    localparam logic [2:0] SubPush = 3'd4;
    localparam logic [2:0] SubCall = 3'd5;

    // ALU op codes issued for single-ops
    localparam int unsigned OpRrc   = 'h10;
    localparam int unsigned OpRrcB  = 'h11;
    localparam int unsigned OpSwpb  = 'h12;
    localparam int unsigned OpRra   = 'h13;
    localparam int unsigned OpRraB  = 'h14;
    localparam int unsigned OpSxt   = 'h15;
    localparam int unsigned OpPush  = 'h16;
    localparam int unsigned OpPushB = 'h17;
    localparam int unsigned OpCall  = 'h18;

    // Double-ops: op_code = opcode nibble - OpDoubleBase
    localparam int unsigned OpDoubleBase = 4;
    localparam int unsigned OpCmp        = 'h05;
    localparam int unsigned OpBit        = 'h07;

    localparam logic [2:0] CondJne = 3'd0;
    localparam logic [2:0] CondJeq = 3'd1;
    localparam logic [2:0] CondJnc = 3'd2;
    localparam logic [2:0] CondJc  = 3'd3;
    localparam logic [2:0] CondJn  = 3'd4;
    localparam logic [2:0] CondJge = 3'd5;
    localparam logic [2:0] CondJl  = 3'd6;
    localparam logic [2:0] CondJmp = 3'd7;

    localparam int unsigned SpIdx = 1;

    // flags are {V,N,Z,C}
    function automatic logic cond_taken(input logic [2:0] cond, input logic [3:0] flags);
        logic v, n, z, c, taken;
        {v, n, z, c} = flags;
        case (cond)
            CondJne: taken = !z;
            CondJeq: taken = z;
            CondJnc: taken = !c;
            CondJc:  taken = c;
            CondJn:  taken = n;
            CondJge: taken = (n == v);
            CondJl:  taken = (n != v);
            CondJmp: taken = 1'b1;
            default: taken = 1'b1;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational instruction decode: IR to class, op_code, register addresses,
// branch offset and byte mode. Fields that do not apply to a class decode to zero.
module ctrl_seq_decode
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned PC_W    = 16,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned OP_W    = 5
) (
    input  logic [INSTR_W-1:0] ir_i,
    output cls_e               cls_o,
    output logic [OP_W-1:0]    op_o,
    output logic [REG_AW-1:0]  src_o,
    output logic [REG_AW-1:0]  dst_o,
    output logic [REG_AW-1:0]  wr_o,
    output logic [PC_W-1:0]    offset_o,
    output logic               byte_o,
    output logic [2:0]         cond_o
);

    logic signed [10:0] jmp_off;
    logic [REG_AW-1:0]  reg_lo;
    logic [REG_AW-1:0]  reg_hi;
    logic [2:0]         sub_op;

    // Word offset scaled to bytes; the signed cast below sign-extends to PC_W
    assign jmp_off = signed'({ir_i[9:0], 1'b0});
    assign reg_lo  = REG_AW'(ir_i[3:0]);
    assign reg_hi  = REG_AW'(ir_i[11:8]);
    assign sub_op  = ir_i[9:7];
    assign cond_o  = ir_i[12:10];

    always_comb begin
        cls_o    = ClsIllegal;
        op_o     = '0;
        src_o    = '0;
        dst_o    = '0;
        wr_o     = '0;
        offset_o = '0;
        byte_o   = 1'b0;

        if (ir_i[15:13] == 3'b001) begin
            cls_o    = ClsJump;
            offset_o = PC_W'(jmp_off);
        end else if (ir_i[15:10] == 6'b000100) begin
            cls_o  = ClsAlu;
            byte_o = ir_i[6];
            dst_o  = reg_lo;
            wr_o   = reg_lo;
            case (sub_op)
                SubRrc:  op_o = OP_W'(ir_i[6] ? OpRrcB : OpRrc);
                SubSwpb: op_o = OP_W'(OpSwpb);
                SubRra:  op_o = OP_W'(ir_i[6] ? OpRraB : OpRra);
                SubSxt:  op_o = OP_W'(OpSxt);
                SubPush: begin
                    op_o  = OP_W'(ir_i[6] ? OpPushB : OpPush);
                    src_o = reg_lo;
                    dst_o = '0;
                    wr_o  = REG_AW'(SpIdx);
                end
                SubCall: begin
                    op_o = OP_W'(OpCall);
                    wr_o = REG_AW'(SpIdx);
                end
                default: begin
                    // RETI and sub-op 7 are not supported
                    cls_o  = ClsIllegal;
                    byte_o = 1'b0;
                    dst_o  = '0;
                    wr_o   = '0;
                end
            endcase
        end else if (ir_i[15:12] >= 4'h4) begin
            cls_o  = ClsAlu;
            op_o   = OP_W'(ir_i[15:12] - 4'(OpDoubleBase));
            src_o  = reg_hi;
            dst_o  = reg_lo;
            wr_o   = reg_lo;
            byte_o = ir_i[6];
        end
    end

endmodule

// File: rtl/ctrl_seq_unit.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the MSP430-style core.
// Define CTRL_SINGLE_STEP_EN to add a step input and halt after every instruction.
module ctrl_seq_unit
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned PC_W    = 16,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned OP_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               fetch_req,
    input  logic [3:0]         flags,
    output logic               pc_inc,
    output logic               branch_en,
    output logic [PC_W-1:0]    pc_offset,
    output logic [REG_AW-1:0]  src_reg,
    output logic [REG_AW-1:0]  dst_reg,
    output logic [REG_AW-1:0]  wr_reg,
    output logic               wr_en,
    output logic [OP_W-1:0]    op_code,
    output logic               byte_mode,
    output logic               illegal,
    output logic [5:0]         fsm_state
);

    if (INSTR_W != 16) begin : g_instr_w_check
        $error("ctrl_seq_unit: only INSTR_W == 16 is supported");
    end
    if (PC_W < 11) begin : g_pc_w_check
        $error("ctrl_seq_unit: PC_W must be at least 11");
    end

    state_e              state_q, state_d;
    state_e              done_st;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    cls_e                cls_q, cls_d;
    logic [2:0]          cond_q, cond_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [REG_AW-1:0]   src_q, src_d;
    logic [REG_AW-1:0]   dst_q, dst_d;
    logic [REG_AW-1:0]   wr_q, wr_d;
    logic [PC_W-1:0]     off_q, off_d;
    logic                byte_q, byte_d;
    logic                no_write;

    cls_e                dec_cls;
    logic [OP_W-1:0]     dec_op;
    logic [REG_AW-1:0]   dec_src, dec_dst, dec_wr;
    logic [PC_W-1:0]     dec_off;
    logic                dec_byte;
    logic [2:0]          dec_cond;

    ctrl_seq_decode #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W),
        .REG_AW  (REG_AW),
        .OP_W    (OP_W)
    ) u_decode (
        .ir_i     (ir_q),
        .cls_o    (dec_cls),
        .op_o     (dec_op),
        .src_o    (dec_src),
        .dst_o    (dec_dst),
        .wr_o     (dec_wr),
        .offset_o (dec_off),
        .byte_o   (dec_byte),
        .cond_o   (dec_cond)
    );

    // Where the FSM goes once an instruction has finished
`ifdef CTRL_SINGLE_STEP_EN
    assign done_st = StHalt;
`else
    assign done_st = StFetch;
`endif

    assign no_write = (op_q == OP_W'(OpCmp)) || (op_q == OP_W'(OpBit));

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cls_d     = cls_q;
        cond_d    = cond_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        wr_d      = wr_q;
        off_d     = off_q;
        byte_d    = byte_q;
        fetch_req = 1'b0;
        pc_inc    = 1'b0;
        branch_en = 1'b0;
        wr_en     = 1'b0;
        illegal   = 1'b0;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                fetch_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr;
                    pc_inc  = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_cls == ClsIllegal) begin
                    // Visible outputs keep the last legal instruction's values
                    illegal = 1'b1;
                    state_d = done_st;
                end else begin
                    cls_d   = dec_cls;
                    cond_d  = dec_cond;
                    op_d    = dec_op;
                    src_d   = dec_src;
                    dst_d   = dec_dst;
                    wr_d    = dec_wr;
                    off_d   = dec_off;
                    byte_d  = dec_byte;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cls_q == ClsJump) begin
                    branch_en = cond_taken(cond_q, flags);
                    state_d   = done_st;
                end else if (no_write) begin
                    state_d = done_st;
                end else begin
                    state_d = StWb;
                end
            end
            StWb: begin
                wr_en   = 1'b1;
                state_d = done_st;
            end
            StHalt: begin
`ifdef CTRL_SINGLE_STEP_EN
                if (step) begin
                    state_d = StFetch;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ir_q    <= '0;
            cls_q   <= ClsAlu;
            cond_q  <= '0;
            op_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            wr_q    <= '0;
            off_q   <= '0;
            byte_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cls_q   <= cls_d;
            cond_q  <= cond_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            wr_q    <= wr_d;
            off_q   <= off_d;
            byte_q  <= byte_d;
        end
    end

    assign fsm_state = state_q;
    assign op_code   = op_q;
    assign src_reg   = src_q;
    assign dst_reg   = dst_q;
    assign wr_reg    = wr_q;
    assign pc_offset = off_q;
    assign byte_mode = byte_q;

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Self-checking bench for ctrl_seq_unit: directed literal checks plus a
// cycle-level behavioural model compared every cycle under random stimulus.
module tb_ctrl_seq_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic [3:0]  flags = '0;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic        fetch_req, pc_inc, branch_en, wr_en, byte_mode, illegal;
    logic [15:0] pc_offset;
    logic [3:0]  src_reg, dst_reg, wr_reg;
    logic [4:0]  op_code;
    logic [5:0]  fsm_state;

    always #5 clk = ~clk;

    ctrl_seq_unit #(
        .INSTR_W (16),
        .PC_W    (16),
        .REG_AW  (4),
        .OP_W    (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CTRL_SINGLE_STEP_EN
        .step        (step),
`endif
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_req   (fetch_req),
        .flags       (flags),
        .pc_inc      (pc_inc),
        .branch_en   (branch_en),
        .pc_offset   (pc_offset),
        .src_reg     (src_reg),
        .dst_reg     (dst_reg),
        .wr_reg      (wr_reg),
        .wr_en       (wr_en),
        .op_code     (op_code),
        .byte_mode   (byte_mode),
        .illegal     (illegal),
        .fsm_state   (fsm_state)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          legal;
        bit          jump;
        bit          writes;
        logic [4:0]  op;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [3:0]  wr;
        bit          bm;
        logic [15:0] off;
        int          cond;
    } mdec_t;

    function automatic mdec_t mdecode(input logic [15:0] i);
        mdec_t d;
        int    sub;
        int    v;
        d.legal = 0; d.jump = 0; d.writes = 0; d.op = 0; d.src = 0; d.dst = 0;
        d.wr = 0; d.bm = 0; d.off = 0; d.cond = int'(i[12:10]);
        if (i[15:13] == 3'b001) begin
            d.legal = 1;
            d.jump  = 1;
            v = int'(i[9:0]);
            if (v >= 512) v -= 1024;
            d.off = 16'(v * 2);
        end else if (i[15:10] == 6'b000100) begin
            sub = int'(i[9:7]);
            if (sub < 6) begin
                d.legal  = 1;
                d.writes = 1;
                d.bm     = i[6];
                case (sub)
                    0: d.op = i[6] ? 5'h11 : 5'h10;
                    1: d.op = 5'h12;
                    2: d.op = i[6] ? 5'h14 : 5'h13;
                    3: d.op = 5'h15;
                    4: d.op = i[6] ? 5'h17 : 5'h16;
                    default: d.op = 5'h18;
                endcase
                if (sub == 4) begin
                    d.src = i[3:0];
                    d.wr  = 4'd1;
                end else if (sub == 5) begin
                    d.dst = i[3:0];
                    d.wr  = 4'd1;
                end else begin
                    d.dst = i[3:0];
                    d.wr  = i[3:0];
                end
            end
        end else if (i[15:12] >= 4'h4) begin
            d.legal  = 1;
            d.op     = 5'(int'(i[15:12]) - 4);
            d.src    = i[11:8];
            d.dst    = i[3:0];
            d.wr     = i[3:0];
            d.bm     = i[6];
            d.writes = !(d.op == 5'h05 || d.op == 5'h07);
        end
        return d;
    endfunction

    function automatic bit mtaken(input int c, input logic [3:0] f);
        bit v, n, z, cy;
        v = f[3]; n = f[2]; z = f[1]; cy = f[0];
        case (c)
            0: return !z;
            1: return z;
            2: return !cy;
            3: return cy;
            4: return n;
            5: return n == v;
            6: return n != v;
            default: return 1'b1;
        endcase
    endfunction

    // m_since counts cycles since the accepting fetch (1 = decode cycle)
    bit          m_idle = 1, m_fetch = 0, m_halt = 0;
    int          m_since = 0;
    mdec_t       m_cur;
    logic [4:0]  m_op = 0;
    logic [3:0]  m_src = 0, m_dst = 0, m_wr = 0;
    bit          m_bm = 0;
    logic [15:0] m_off = 0;

    task automatic model_reset();
        m_idle = 1; m_fetch = 0; m_halt = 0; m_since = 0;
        m_op = 0; m_src = 0; m_dst = 0; m_wr = 0; m_bm = 0; m_off = 0;
        m_cur = mdecode(16'h0000);
    endtask

    task automatic model_complete();
`ifdef CTRL_SINGLE_STEP_EN
        m_halt = 1;
`else
        m_fetch = 1;
`endif
    endtask

    task automatic model_advance();
        int len;
        if (m_idle) begin
            m_idle  = 0;
            m_fetch = 1;
        end else if (m_fetch) begin
            if (instr_valid) begin
                m_fetch = 0;
                m_since = 1;
                m_cur   = mdecode(instr);
            end
        end else if (m_halt) begin
`ifdef CTRL_SINGLE_STEP_EN
            if (step) begin
                m_halt  = 0;
                m_fetch = 1;
            end
`endif
        end else begin
            if (m_since == 1 && m_cur.legal) begin
                m_op = m_cur.op; m_src = m_cur.src; m_dst = m_cur.dst; m_wr = m_cur.wr;
                m_bm = m_cur.bm; m_off = m_cur.off;
            end
            len = !m_cur.legal ? 2 : (m_cur.writes ? 4 : 3);
            if (m_since + 1 == len) begin
                m_since = 0;
                model_complete();
            end else begin
                m_since++;
            end
        end
    endtask

    always @(negedge clk) begin
        logic [5:0]  e_fsm;
        logic [10:0] e_ctrl;
        logic [33:0] e_regs;
        #3;
        if (rst) model_reset();
        if (m_idle)       e_fsm = 6'b000001;
        else if (m_fetch) e_fsm = 6'b000010;
        else if (m_halt)  e_fsm = 6'b100000;
        else              e_fsm = 6'(1 << (m_since + 1));
        e_ctrl = {e_fsm, m_fetch, m_fetch && instr_valid,
                  (m_since == 2) && m_cur.jump && mtaken(m_cur.cond, flags),
                  (m_since == 3), (m_since == 1) && !m_cur.legal};
        e_regs = {m_op, m_src, m_dst, m_wr, m_bm, m_off};
        check("model_ctrl", {fsm_state, fetch_req, pc_inc, branch_en, wr_en, illegal}, e_ctrl);
        check("model_regs", {op_code, src_reg, dst_reg, wr_reg, byte_mode, pc_offset}, e_regs);
        if (!rst) model_advance();
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 4))
            0: r[15:13] = 3'b001;
            1: r[15:10] = 6'b000100;
            2: r[15:12] = 4'(4 + $urandom_range(0, 11));
            3: r[15:12] = ($urandom_range(0, 1) == 1) ? 4'h9 : 4'hB;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        #1 rst = 1'b1;
        instr = 16'h5506;
        instr_valid = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        check("rst_fsm", fsm_state, 6'b000001);
        check("rst_fetch_req", fetch_req, 0);
        check("rst_op_code", op_code, 0);
        check("rst_pc_offset", pc_offset, 0);
`ifndef CTRL_SINGLE_STEP_EN
        @(negedge clk); rst = 1'b0;
        #3 check("idle_fsm", fsm_state, 6'b000001);
        @(negedge clk);
        #3 check("add_pc_inc_c1", pc_inc, 1);
        repeat (2) @(negedge clk);
        #3;
        check("add_op", op_code, 5'h01);
        check("add_src", src_reg, 5);
        check("add_dst", dst_reg, 6);
        check("add_wr_reg", wr_reg, 6);
        @(negedge clk);
        #3 check("add_wr_en_c4", wr_en, 1);
        @(negedge clk); instr = 16'h9203;
        #3 check("add_refetch_c5", fetch_req, 1);
        repeat (2) @(negedge clk);
        #3;
        check("cmp_op", op_code, 5'h05);
        check("cmp_no_wr", wr_en, 0);
        @(negedge clk); instr = 16'h2404; flags = 4'b0010;
        #3 check("cmp_refetch", fetch_req, 1);
        repeat (2) @(negedge clk);
        #3;
        check("jeq_taken", branch_en, 1);
        check("jeq_offset", pc_offset, 16'h0008);
        @(negedge clk); flags = 4'b0000;
        #3 check("jeq_refetch", fetch_req, 1);
        repeat (2) @(negedge clk);
        #3 check("jeq_not_taken", branch_en, 0);
        @(negedge clk); instr = 16'h3FFF;
        repeat (2) @(negedge clk);
        #3;
        check("jmp_offset", pc_offset, 16'hFFFE);
        check("jmp_taken", branch_en, 1);
        @(negedge clk); instr_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            check("wait_fetch_req", fetch_req, 1);
            check("wait_no_pc_inc", pc_inc, 0);
        end
        @(negedge clk); instr = 16'h0000; instr_valid = 1'b1;
        #3 check("wait_accept", pc_inc, 1);
        @(negedge clk);
        #3;
        check("ill0_pulse", illegal, 1);
        check("ill0_no_wr", wr_en, 0);
        @(negedge clk); instr = 16'h1300;
        #3 check("ill0_refetch", fetch_req, 1);
        @(negedge clk);
        #3;
        check("reti_pulse", illegal, 1);
        check("reti_no_branch", branch_en, 0);
        @(negedge clk); instr = 16'h5506;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk); instr_valid = 1'b1; instr = 16'h4ABC;
        #3 check("exec_valid_ignored", pc_inc, 0);
        @(negedge clk); instr_valid = 1'b0;
        #3 check("wb_after_ignore", wr_en, 1);
        @(negedge clk);
        #3 check("ignore_refetch", fetch_req, 1);
        @(negedge clk); instr_valid = 1'b1; instr = 16'h5506;
        repeat (3) @(negedge clk);
        #1 check("wb_before_rst", wr_en, 1);
        rst = 1'b1;
        #1;
        check("rst_wb_wr_en", wr_en, 0);
        check("rst_wb_fetch_req", fetch_req, 0);
        check("rst_wb_fsm", fsm_state, 6'b000001);
        @(negedge clk); rst = 1'b0;
`else
        @(negedge clk); rst = 1'b0; step = 1'b0; instr = 16'h9203;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #3;
            check("halt_fsm", fsm_state, 6'b100000);
            check("halt_no_fetch", fetch_req, 0);
        end
        @(negedge clk); step = 1'b1;
        #3 check("halt_step_cycle", fsm_state, 6'b100000);
        @(negedge clk); step = 1'b0;
        #3 check("halt_released", fetch_req, 1);
`endif
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 399) == 0);
            instr       = rand_instr();
            instr_valid = ($urandom_range(0, 9) < 7);
            flags       = 4'($urandom);
`ifdef CTRL_SINGLE_STEP_EN
            step        = ($urandom_range(0, 2) == 0);
`endif
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        #5;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
